// File: rtl/bsg_fifo_en_bypass_if.sv
// Handshake bundle for bsg_fifo_en_bypass: ready&valid producer side in,
// valid-yumi consumer side out, plus the storage occupancy.
interface bsg_fifo_en_bypass_if #(
  parameter int width_p = 32,
  parameter int els_p   = 4
);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic                v_i;
  logic [width_p-1:0]  data_i;
  logic                ready_o;
  logic                v_o;
  logic [width_p-1:0]  data_o;
  logic                yumi_i;
  logic [cnt_w_lp-1:0] count_o;

  // Environment side: produces words and consumes the output.
  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );

  // FIFO side.
  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_fifo_en_bypass.sv
// Fall-through FIFO of els_p words. With bypass_p=1 an empty FIFO forwards
// data_i straight to data_o; otherwise words are buffered until yumi_i.
module bsg_fifo_en_bypass #(
  parameter int width_p  = 32,
  parameter int els_p    = 4,
  parameter int bypass_p = 1
) (
  input logic              clk_i,
  input logic              reset_n_i,
  bsg_fifo_en_bypass_if.slave io
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
  localparam bit bypass_lp = (bypass_p != 0);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rptr_reg, rptr_next;
  logic [ptr_w_lp-1:0] wptr_reg, wptr_next;
  logic [cnt_w_lp-1:0] count_reg, count_next;

  logic empty;
  logic bypassing;
  logic enq;
  logic enq_store;
  logic deq_store;

  // Explicit wrap so non-power-of-2 depths index correctly.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Handshake decode; ready depends on registered state only (and reset).
  always_comb begin
    empty      = (count_reg == '0);
    bypassing  = bypass_lp && empty;
    io.ready_o = reset_n_i && (count_reg != full_cnt_lp);
    io.v_o     = reset_n_i && (empty ? (bypass_lp && io.v_i) : 1'b1);
    io.data_o  = bypassing ? io.data_i : mem[rptr_reg];
    io.count_o = count_reg;
    enq        = io.v_i && io.ready_o;
    // A word consumed in the same cycle it bypasses is never stored.
    enq_store  = enq && !(bypassing && io.yumi_i);
    deq_store  = io.yumi_i && !empty;
  end

  // Next-state pointer and occupancy arithmetic.
  always_comb begin
    rptr_next  = deq_store ? ptr_inc(rptr_reg) : rptr_reg;
    wptr_next  = enq_store ? ptr_inc(wptr_reg) : wptr_reg;
    count_next = count_reg;
    if (enq_store && !deq_store)
      count_next = count_reg + cnt_w_lp'(1);
    else if (!enq_store && deq_store)
      count_next = count_reg - cnt_w_lp'(1);
  end

  // Pointer/count state; contents are discarded the moment reset asserts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  // Storage array is deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (enq_store)
      mem[wptr_reg] <= io.data_i;
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io.yumi_i && !io.v_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_reg <= full_cnt_lp);
  a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !$isunknown({io.v_i, io.yumi_i}));
endmodule

// File: tb/tb_bsg_fifo_en_bypass.sv
// Directed bench: a 4-deep bypass FIFO driven from a vector table, and a
// 3-deep registered FIFO exercised by a streaming wrap-around sequence.
module tb_bsg_fifo_en_bypass;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bsg_fifo_en_bypass_if #(.width_p(32), .els_p(4)) a_if ();
  bsg_fifo_en_bypass_if #(.width_p(32), .els_p(3)) b_if ();

  bsg_fifo_en_bypass #(.width_p(32), .els_p(4), .bypass_p(1)) dut_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .io(a_if.slave));
  bsg_fifo_en_bypass #(.width_p(32), .els_p(3), .bypass_p(0)) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .io(b_if.slave));

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        y;
    logic        exp_rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [2:0]  exp_cnt;
    logic        chk_d;
  } vec_t;

  vec_t vecs[17];
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  initial begin
    int sent;
    int recv;
    bit tog;

    a_if.v_i = 1'b1; a_if.data_i = 32'hDEADBEEF; a_if.yumi_i = 1'b0;
    b_if.v_i = 1'b0; b_if.data_i = '0;           b_if.yumi_i = 1'b0;

    //             v  d             y  rdy v  exp_d         cnt  chk_d
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 3'd0, 1'b1};
    vecs[1]  = '{1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h12345678, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[3]  = '{1'b1, 32'h1,        1'b0, 1'b1, 1'b1, 32'h1,        3'd0, 1'b1};
    vecs[4]  = '{1'b1, 32'h2,        1'b0, 1'b1, 1'b1, 32'h1,        3'd1, 1'b1};
    vecs[5]  = '{1'b1, 32'h3,        1'b0, 1'b1, 1'b1, 32'h1,        3'd2, 1'b1};
    vecs[6]  = '{1'b1, 32'h4,        1'b0, 1'b1, 1'b1, 32'h1,        3'd3, 1'b1};
    vecs[7]  = '{1'b1, 32'h5,        1'b0, 1'b0, 1'b1, 32'h1,        3'd4, 1'b1};
    vecs[8]  = '{1'b1, 32'h5,        1'b1, 1'b0, 1'b1, 32'h1,        3'd4, 1'b1};
    vecs[9]  = '{1'b1, 32'h5,        1'b1, 1'b1, 1'b1, 32'h2,        3'd3, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h3,        3'd3, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        3'd2, 1'b1};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h5,        3'd1, 1'b1};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[14] = '{1'b1, 32'hA1,       1'b0, 1'b1, 1'b1, 32'hA1,       3'd0, 1'b1};
    vecs[15] = '{1'b1, 32'hA2,       1'b0, 1'b1, 1'b1, 32'hA1,       3'd1, 1'b1};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA1,       3'd2, 1'b1};

    // Reset held for three cycles with a valid word presented.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #4;
      check($sformatf("rst%0d_ready", i), 32'(a_if.ready_o), 32'd0);
      check($sformatf("rst%0d_v", i),     32'(a_if.v_o),     32'd0);
      check($sformatf("rst%0d_count", i), 32'(a_if.count_o), 32'd0);
    end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Table-driven single-cycle vectors on the bypass FIFO.
    for (int i = 0; i < 17; i++) begin
      a_if.v_i = vecs[i].v; a_if.data_i = vecs[i].d; a_if.yumi_i = vecs[i].y;
      #3;
      check($sformatf("vec%0d_ready", i), 32'(a_if.ready_o), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_v", i),     32'(a_if.v_o),     32'(vecs[i].exp_v));
      check($sformatf("vec%0d_count", i), 32'(a_if.count_o), 32'(vecs[i].exp_cnt));
      if (vecs[i].chk_d)
        check($sformatf("vec%0d_data", i), a_if.data_o, vecs[i].exp_d);
      @(posedge clk_i); #1;
    end

    // Reset mid-operation with two words stored.
    reset_n_i = 1'b0;
    #1;
    check("midrst_v",     32'(a_if.v_o),     32'd0);
    check("midrst_count", 32'(a_if.count_o), 32'd0);
    check("midrst_ready", 32'(a_if.ready_o), 32'd0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    #3;
    check("postrst_v",     32'(a_if.v_o),     32'd0);
    check("postrst_count", 32'(a_if.count_o), 32'd0);
    check("postrst_ready", 32'(a_if.ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Wrap-around stream through the 3-deep registered FIFO.
    sent = 0; recv = 0; tog = 1'b1;
    for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
      b_if.v_i    = (sent < 10);
      b_if.data_i = 32'(sent);
      b_if.yumi_i = tog & b_if.v_o;
      #3;
      if (cyc == 0) check("b_first_latency_v0", 32'(b_if.v_o), 32'd0);
      if (cyc == 1) check("b_first_latency_v1", 32'(b_if.v_o), 32'd1);
      check($sformatf("b_cyc%0d_count_le3", cyc), 32'(b_if.count_o <= 2'd3), 32'd1);
      if (b_if.yumi_i) begin
        check($sformatf("b_word%0d", recv), b_if.data_o, 32'(recv));
        recv++;
      end
      if (b_if.v_i && b_if.ready_o) sent++;
      tog = ~tog;
      @(posedge clk_i); #1;
    end
    b_if.v_i = 1'b0; b_if.yumi_i = 1'b0;
    check("b_words_received", 32'(recv), 32'd10);
    #3;
    check("b_drained_count", 32'(b_if.count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
